// File: rtl/cla_multiword_seq_adder_pkg.sv
// Shared constants and types for the multi-word CLA add/subtract sequencer.
package cla_multiword_seq_adder_pkg;

   // Width of one carry-lookahead slice; operands are processed this many bits per cycle.
   localparam int SLICE_W = 5;

   // Sequencer states: waiting for a request, rippling slices, presenting the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cla_multiword_seq_adder_if.sv
// Request/result handshake bundle for the multi-word sequential adder.
interface cla_multiword_seq_adder_if
   import cla_multiword_seq_adder_pkg::*;
#(
   parameter int WORDS = 4
);
   localparam int W = SLICE_W * WORDS;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;

   // Requester / result consumer side.
   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );

   // Adder side.
   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );

endinterface

// File: rtl/cla_multiword_seq_adder_cla.sv
// Combinational 5-bit carry-lookahead adder slice built from generate/propagate terms.
module carry_lookahead_adder_5bit_gates
   import cla_multiword_seq_adder_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);
   logic [SLICE_W-1:0] g_s;
   logic [SLICE_W-1:0] p_s;
   logic [SLICE_W:0]   c_s;

   assign g_s = a & b;
   assign p_s = a ^ b;

   // Every carry is expanded directly from cin so no carry ripples inside the slice.
   assign c_s[0] = cin;
   assign c_s[1] = g_s[0] | (p_s[0] & cin);
   assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
   assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                 | (p_s[2] & p_s[1] & p_s[0] & cin);
   assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                 | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                 | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
   assign c_s[5] = g_s[4] | (p_s[4] & g_s[3]) | (p_s[4] & p_s[3] & g_s[2])
                 | (p_s[4] & p_s[3] & p_s[2] & g_s[1])
                 | (p_s[4] & p_s[3] & p_s[2] & p_s[1] & g_s[0])
                 | (p_s[4] & p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);

   assign sum  = p_s ^ c_s[SLICE_W-1:0];
   assign cout = c_s[SLICE_W];

endmodule

// File: rtl/cla_multiword_seq_adder.sv
// Multi-precision add/subtract sequencer: one 5-bit CLA slice per cycle, LSB chunk first,
// with the slice carry rippled through a register between cycles.
module cla_multiword_seq_adder
   import cla_multiword_seq_adder_pkg::*;
#(
   parameter int WORDS = 4
)(
   input logic                      clk,
   input logic                      rst,
   cla_multiword_seq_adder_if.slave bus
);
   localparam int                W        = SLICE_W * WORDS;
   localparam int                IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

   state_t             state_r;
   logic [W-1:0]       a_r;
   logic [W-1:0]       b_r;           // already inverted for subtraction
   logic [W-1:0]       sum_r;
   logic               carry_r;
   logic [IDX_W-1:0]   idx_r;
   logic               in_ready_r;
   logic               out_valid_r;
   logic [W-1:0]       out_sum_r;
   logic               out_cout_r;
   logic               out_ovf_r;

   int unsigned        base_s;
   logic [SLICE_W-1:0] chunk_a_s;
   logic [SLICE_W-1:0] chunk_b_s;
   logic [SLICE_W-1:0] slice_sum_s;
   logic               slice_cout_s;
   logic               ovf_s;

   // Chunks come only from the registered operands, never from the request bus.
   assign base_s    = 32'(idx_r) * 32'(SLICE_W);
   assign chunk_a_s = a_r[base_s +: SLICE_W];
   assign chunk_b_s = b_r[base_s +: SLICE_W];

   // Signed overflow: operands agree in sign but the result does not.
   assign ovf_s = (a_r[W-1] == b_r[W-1]) && (sum_r[W-1] != a_r[W-1]);

   carry_lookahead_adder_5bit_gates u_slice (
      .a    (chunk_a_s),
      .b    (chunk_b_s),
      .cin  (carry_r),
      .sum  (slice_sum_s),
      .cout (slice_cout_s)
   );

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_sum   = out_sum_r;
   assign bus.out_cout  = out_cout_r;
   assign bus.out_ovf   = out_ovf_r;

   // Sequencer FSM with operand, sum, carry, index and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         a_r         <= '0;
         b_r         <= '0;
         sum_r       <= '0;
         carry_r     <= 1'b0;
         idx_r       <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_sum_r   <= '0;
         out_cout_r  <= 1'b0;
         out_ovf_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  a_r        <= bus.in_a;
                  b_r        <= bus.in_sub ? ~bus.in_b : bus.in_b;
                  carry_r    <= bus.in_sub ? 1'b1 : bus.in_cin;
                  idx_r      <= '0;
                  in_ready_r <= 1'b0;
                  state_r    <= RUN;
               end
            end
            RUN: begin
               sum_r[base_s +: SLICE_W] <= slice_sum_s;
               carry_r                  <= slice_cout_s;
               if (idx_r == LAST_IDX) begin
                  state_r <= DONE;
               end else begin
                  idx_r <= idx_r + IDX_W'(1);
               end
            end
            DONE: begin
               // First DONE cycle publishes the result; afterwards it is held until taken.
               if (!out_valid_r) begin
                  out_sum_r   <= sum_r;
                  out_cout_r  <= carry_r;
                  out_ovf_r   <= ovf_s;
                  out_valid_r <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cla_multiword_seq_adder.sv
// Self-checking bench for cla_multiword_seq_adder (WORDS=4, 20-bit operands).
module tb_cla_multiword_seq_adder;
   localparam int WORDS = 4;
   localparam int W     = 20;

   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   cla_multiword_seq_adder_if #(.WORDS(WORDS)) bus ();

   cla_multiword_seq_adder #(.WORDS(WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain W-bit arithmetic, overflow from the signed range of the true result.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub,
                                 output logic [W-1:0] s, output logic co, output logic ov);
      logic [W-1:0] be;
      logic [W:0]   full;
      int           c, sr;
      be   = sub ? ~b : b;
      c    = sub ? 1 : int'(cin);
      full = {1'b0, a} + {1'b0, be} + 21'(c);
      s    = full[W-1:0];
      co   = full[W];
      sr   = int'($signed(a)) + int'($signed(be)) + c;
      ov   = (sr > 524287) || (sr < -524288);
   endfunction

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
      int n;
      @(negedge clk);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_sub   = sub;
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_check(input string tag, input int exp_lat, input logic [W-1:0] es,
                             input logic ec, input logic eo);
      int lat;
      @(negedge clk);
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.out_valid === 1'b1) break;
      end
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      if (exp_lat > 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_sum"}, 32'(bus.out_sum), 32'(es));
      chk({tag, "_cout"}, 32'(bus.out_cout), 32'(ec));
      chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(eo));
   endtask

   task automatic release_check(input string tag);
      @(negedge clk);
      chk({tag, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_rel_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      logic [W-1:0] ra, rb, es, hold_sum;
      logic         rc, rs, ec, eo;
      logic         seen_valid;

      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b1;

      // 1. asynchronous reset asserted between clock edges
      #7 rst = 1'b1;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
      chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
      chk("rst_out_cout", 32'(bus.out_cout), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 2. carry out of the top bit, with exact latency
      send(20'h00001, 20'hFFFFF, 1'b0, 1'b0);
      wait_check("add_wrap", 5, 20'h00000, 1'b1, 1'b0);
      release_check("add_wrap");

      // 3. subtraction with and without borrow
      send(20'h00005, 20'h00007, 1'b0, 1'b1);
      wait_check("sub_neg", 5, 20'hFFFFE, 1'b0, 1'b0);
      release_check("sub_neg");
      send(20'h00007, 20'h00005, 1'b1, 1'b1);
      wait_check("sub_pos", 5, 20'h00002, 1'b1, 1'b0);
      release_check("sub_pos");

      // 4 + 5. positive overflow held under back-pressure, spurious requests ignored
      bus.out_ready = 1'b0;
      send(20'h7FFFF, 20'h00001, 1'b0, 1'b0);
      wait_check("ovf_add", 5, 20'h80000, 1'b0, 1'b1);
      hold_sum = bus.out_sum;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_a     = 20'($urandom);
         bus.in_b     = 20'($urandom);
         @(negedge clk);
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_sum", 32'(bus.out_sum), 32'(hold_sum));
         chk("bp_cout", 32'(bus.out_cout), 32'd0);
         chk("bp_ovf", 32'(bus.out_ovf), 32'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      release_check("bp");

      // 4. negative overflow on subtraction, right after back-pressure
      send(20'h80000, 20'h00001, 1'b0, 1'b1);
      wait_check("ovf_sub", 5, 20'h7FFFF, 1'b1, 1'b1);
      release_check("ovf_sub");

      // 6. reset while slice 2 is in progress discards the operation
      send(20'hABCDE, 20'h13579, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrun_rst_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) seen_valid = 1'b1;
      end
      chk("midrun_no_valid", 32'(seen_valid), 32'd0);
      chk("midrun_in_ready", 32'(bus.in_ready), 32'd1);
      send(20'h12345, 20'h0ABCD, 1'b1, 1'b0);
      wait_check("after_rst", 5, 20'h1CF13, 1'b0, 1'b0);
      release_check("after_rst");

      // randomized operations against the arithmetic reference
      for (int i = 0; i < 24; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? 20'h7FFFF : 20'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? 20'h80000 : 20'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom);
         model(ra, rb, rc, rs, es, ec, eo);
         send(ra, rb, rc, rs);
         wait_check("rand", 5, es, ec, eo);
         release_check("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
